// File: rtl/alien_fire_ctrl_if.sv
// Alien-to-missile link: fire pulse and motion code out, in-flight flag back.
interface alien_fire_ctrl_if;
  logic       shoot_missile;
  logic [1:0] motion_code;
  logic       missile_visible;

  modport master (output shoot_missile, output motion_code, input missile_visible);
  modport slave  (input shoot_missile, input motion_code, output missile_visible);
endinterface

// File: rtl/alien_fire_ctrl.sv
// Per-alien attack controller: sequences march/dive/return and issues
// single-frame missile fire pulses, allowing only one live missile at a time.
module alien_fire_ctrl #(
  parameter int unsigned FIRE_INTERVAL = 90,
  parameter bit          JITTER_EN     = 1'b1,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5,
  parameter int unsigned DIVE_INTERVAL = 300,
  parameter int unsigned LEFT_EDGE     = 40,
  parameter int unsigned RIGHT_EDGE    = 575,
  parameter int unsigned ALIEN_SIZE    = 25,
  parameter int unsigned DIVE_FLOOR    = 400,
  parameter int unsigned HOME_Y        = 60,
  parameter int unsigned AIM_WINDOW    = 16
) (
  input  logic                frame_clk,
  input  logic                Reset_n,
  input  logic                enable,
  input  logic                alien_alive,
  input  logic [9:0]          AlienX,
  input  logic [9:0]          AlienY,
  input  logic [9:0]          PlayerX,
  alien_fire_ctrl_if.master   msl,
  output logic                dive_active,
  output logic [7:0]          shots_fired
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned XW    = 11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MARCH_R = 3'd1,
    ST_MARCH_L = 3'd2,
    ST_DIVE    = 3'd3,
    ST_RETURN  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] fire_cnt_q, fire_cnt_d;
  logic [CNT_W-1:0] dive_cnt_q, dive_cnt_d;
  logic [CNT_W-1:0] thr_q, thr_d, thr_cur;
  logic             pending_q, pending_d;
  logic             lost_q, lost_d;
  logic             dsd_q, dsd_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             shoot_q, shoot_d;
  logic [1:0]       code_q, code_d;
  logic             dive_q, dive_d;
  logic [7:0]       shots_q, shots_d;
  logic             fire;

  logic             go, armed, at_right, at_left, dive_due, aim_ok;
  logic [XW-1:0]    aim_diff, aim_abs;

  assign go       = enable & alien_alive;
  assign armed    = ~pending_q & ~msl.missile_visible;
  assign at_right = ({1'b0, AlienX} + XW'(ALIEN_SIZE)) >= XW'(RIGHT_EDGE);
  assign at_left  = {1'b0, AlienX} <= XW'(LEFT_EDGE);
  assign dive_due = dive_cnt_q == CNT_W'(DIVE_INTERVAL - 1);

  // Signed horizontal distance between alien centre and player centre.
  assign aim_diff = ({1'b0, AlienX} + XW'(12)) - ({1'b0, PlayerX} + XW'(20));
  assign aim_abs  = aim_diff[XW-1] ? (~aim_diff + XW'(1)) : aim_diff;
  assign aim_ok   = aim_abs < XW'(AIM_WINDOW);

  // Threshold is latched at the start of each fire interval.
  assign thr_cur  = (fire_cnt_q == '0)
                  ? CNT_W'(FIRE_INTERVAL) + (JITTER_EN ? CNT_W'(lfsr_q[3:0]) : CNT_W'(0))
                  : thr_q;

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      fire_cnt_q <= '0;
      dive_cnt_q <= '0;
      thr_q      <= '0;
      pending_q  <= 1'b0;
      lost_q     <= 1'b0;
      dsd_q      <= 1'b0;
      lfsr_q     <= LFSR_SEED;
      shoot_q    <= 1'b0;
      code_q     <= 2'b11;
      dive_q     <= 1'b0;
      shots_q    <= '0;
    end else begin
      state_q    <= state_d;
      fire_cnt_q <= fire_cnt_d;
      dive_cnt_q <= dive_cnt_d;
      thr_q      <= thr_d;
      pending_q  <= pending_d;
      lost_q     <= lost_d;
      dsd_q      <= dsd_d;
      lfsr_q     <= lfsr_d;
      shoot_q    <= shoot_d;
      code_q     <= code_d;
      dive_q     <= dive_d;
      shots_q    <= shots_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fire_cnt_d = fire_cnt_q;
    dive_cnt_d = dive_cnt_q;
    thr_d      = thr_cur;
    pending_d  = pending_q;
    lost_d     = lost_q;
    dsd_d      = dsd_q;
    lfsr_d     = lfsr_q;
    shots_d    = shots_q;
    fire       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (go) state_d = ST_MARCH_R;
      end
      ST_MARCH_R, ST_MARCH_L: begin
        // Dive start overrides an edge turn on the same frame.
        if (dive_due) begin
          state_d    = ST_DIVE;
          dive_cnt_d = '0;
          dsd_d      = 1'b0;
        end else begin
          dive_cnt_d = dive_cnt_q + CNT_W'(1);
          if (state_q == ST_MARCH_R && at_right)     state_d = ST_MARCH_L;
          else if (state_q == ST_MARCH_L && at_left) state_d = ST_MARCH_R;
        end
        if (armed) begin
          if (fire_cnt_q == thr_cur - CNT_W'(1)) begin
            fire       = go;
            fire_cnt_d = '0;
          end else begin
            fire_cnt_d = fire_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DIVE: begin
        if (AlienY >= 10'(DIVE_FLOOR)) state_d = ST_RETURN;
        if (go && armed && !dsd_q && aim_ok) begin
          fire  = 1'b1;
          dsd_d = 1'b1;
        end
      end
      ST_RETURN: begin
        if (AlienY <= 10'(HOME_Y)) state_d = ST_MARCH_R;
      end
      default: state_d = ST_IDLE;
    endcase

    // A shot stays pending until seen in flight or lost after two frames.
    if (pending_q) begin
      if (msl.missile_visible || lost_q) begin
        pending_d = 1'b0;
        lost_d    = 1'b0;
      end else begin
        lost_d    = 1'b1;
      end
    end
    if (fire) begin
      pending_d = 1'b1;
      lost_d    = 1'b0;
      if (shots_q != 8'hFF) shots_d = shots_q + 8'd1;
    end

    if (state_q != ST_IDLE)
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    if (!go) begin
      state_d    = ST_IDLE;
      fire_cnt_d = '0;
      dive_cnt_d = '0;
      pending_d  = 1'b0;
      lost_d     = 1'b0;
    end

    shoot_d = fire;
    dive_d  = (state_d == ST_DIVE);
    case (state_d)
      ST_MARCH_R: code_d = 2'b00;
      ST_MARCH_L: code_d = 2'b01;
      ST_DIVE:    code_d = 2'b10;
      default:    code_d = 2'b11;
    endcase
  end

  assign msl.shoot_missile = shoot_q;
  assign msl.motion_code   = code_q;
  assign dive_active       = dive_q;
  assign shots_fired       = shots_q;

endmodule

// File: tb/tb_alien_fire_ctrl.sv
// Directed bench for alien_fire_ctrl: vector table for march/dive/return
// plus hand sequences for fire timing, alive drop and asynchronous reset.
module tb_alien_fire_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset_n;
  logic       enable;
  logic       alien_alive;
  logic [9:0] AlienX, AlienY, PlayerX;
  logic       dive_active;
  logic [7:0] shots_fired;

  alien_fire_ctrl_if mif ();

  alien_fire_ctrl #(.JITTER_EN(1'b0)) dut (
    .frame_clk   (frame_clk),
    .Reset_n     (Reset_n),
    .enable      (enable),
    .alien_alive (alien_alive),
    .AlienX      (AlienX),
    .AlienY      (AlienY),
    .PlayerX     (PlayerX),
    .msl         (mif),
    .dive_active (dive_active),
    .shots_fired (shots_fired)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic       en;
    logic       alive;
    int         ax;
    int         ay;
    int         px;
    logic       vis;
    int         frames;
    int         code;
    int         dive;
    int         shoot;
    int         pulses;
    int         shots;
  } vec_t;

  vec_t vt [17];

  int checks = 0;
  int passes = 0;
  int pulse_cnt = 0;
  int bad_frames;
  int consec_viol = 0;
  logic prev_shoot = 1'b0;
  int n;

  always @(negedge frame_clk) begin
    if (mif.shoot_missile && prev_shoot) consec_viol++;
    prev_shoot = mif.shoot_missile;
  end

  task automatic tick();
    @(posedge frame_clk);
    #1;
    if (mif.shoot_missile) pulse_cnt++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic ticks_to_pulse(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!mif.shoot_missile && cnt < 400);
  endtask

  task automatic go_idle();
    enable = 1'b0;
    tick();
    enable = 1'b1;
  endtask

  initial begin
    // Table: march edges, dive aim boundaries, single dive shot, return.
    vt[0]  = '{1'b1, 1'b1, 300, 100,   0, 1'b1,   1, 0, 0, 0, 0, 4};
    vt[1]  = '{1'b1, 1'b1, 550, 100,   0, 1'b1,   1, 1, 0, 0, 0, 4};
    vt[2]  = '{1'b1, 1'b1, 300, 100,   0, 1'b1,   3, 1, 0, 0, 0, 4};
    vt[3]  = '{1'b1, 1'b1,  41, 100,   0, 1'b1,   1, 1, 0, 0, 0, 4};
    vt[4]  = '{1'b1, 1'b1,  40, 100,   0, 1'b1,   1, 0, 0, 0, 0, 4};
    vt[5]  = '{1'b1, 1'b1, 549, 100,   0, 1'b1,   2, 0, 0, 0, 0, 4};
    vt[6]  = '{1'b1, 1'b1, 300, 100,   0, 1'b1, 290, 0, 0, 0, 0, 4};
    vt[7]  = '{1'b1, 1'b1, 300, 100,   0, 1'b1,   1, 0, 0, 0, 0, 4};
    vt[8]  = '{1'b1, 1'b1, 300, 100,   0, 1'b1,   1, 2, 1, 0, 0, 4};
    vt[9]  = '{1'b1, 1'b1, 324, 100, 300, 1'b0,   2, 2, 1, 0, 0, 4};
    vt[10] = '{1'b1, 1'b1, 290, 100, 300, 1'b0,   2, 2, 1, 0, 0, 4};
    vt[11] = '{1'b1, 1'b1, 323, 100, 300, 1'b0,   1, 2, 1, 1, 1, 5};
    vt[12] = '{1'b1, 1'b1, 305, 100, 300, 1'b0,  20, 2, 1, 0, 0, 5};
    vt[13] = '{1'b1, 1'b1, 305, 400, 300, 1'b0,   1, 3, 0, 0, 0, 5};
    vt[14] = '{1'b1, 1'b1, 305, 200, 300, 1'b0,  30, 3, 0, 0, 0, 5};
    vt[15] = '{1'b1, 1'b1, 305,  60, 300, 1'b0,   1, 0, 0, 0, 0, 5};
    vt[16] = '{1'b1, 1'b1, 300,  60, 300, 1'b1,   5, 0, 0, 0, 0, 5};

    Reset_n = 1'b0;
    enable = 1'b0;
    alien_alive = 1'b0;
    AlienX = 10'd0;
    AlienY = 10'd0;
    PlayerX = 10'd0;
    mif.missile_visible = 1'b0;

    // Reset values, then 100 idle frames with enable low.
    repeat (3) tick();
    check("rst_code", int'(mif.motion_code), 3);
    check("rst_shoot", int'(mif.shoot_missile), 0);
    check("rst_dive", int'(dive_active), 0);
    check("rst_shots", int'(shots_fired), 0);
    Reset_n = 1'b1;
    bad_frames = 0;
    pulse_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (mif.motion_code != 2'b11) bad_frames++;
    end
    check("idle_code_frames", bad_frames, 0);
    check("idle_pulses", pulse_cnt, 0);

    // First pulse 90 frames after march entry; lost shot adds 2 frames.
    enable = 1'b1;
    alien_alive = 1'b1;
    AlienX = 10'd300;
    AlienY = 10'd100;
    tick();
    check("entry_code", int'(mif.motion_code), 0);
    ticks_to_pulse(n);
    check("first_pulse_frame", n, 90);
    ticks_to_pulse(n);
    check("lost_shot_gap", n, 92);
    check("shots_after_two", int'(shots_fired), 2);

    // Missile in flight blocks firing; interval restarts after it falls.
    go_idle();
    check("reidle_code", int'(mif.motion_code), 3);
    tick();
    ticks_to_pulse(n);
    check("pulse_after_reentry", n, 90);
    mif.missile_visible = 1'b1;
    pulse_cnt = 0;
    repeat (50) tick();
    check("no_pulse_while_visible", pulse_cnt, 0);
    mif.missile_visible = 1'b0;
    ticks_to_pulse(n);
    check("pulse_after_fall", n, 90);
    check("shots_after_four", int'(shots_fired), 4);

    // Table-driven march/dive/return phase from a fresh IDLE.
    enable = 1'b0;
    tick();
    for (int r = 0; r < 17; r++) begin
      enable = vt[r].en;
      alien_alive = vt[r].alive;
      AlienX = 10'(vt[r].ax);
      AlienY = 10'(vt[r].ay);
      PlayerX = 10'(vt[r].px);
      mif.missile_visible = vt[r].vis;
      pulse_cnt = 0;
      repeat (vt[r].frames) tick();
      check($sformatf("row%0d_code", r), int'(mif.motion_code), vt[r].code);
      check($sformatf("row%0d_dive", r), int'(dive_active), vt[r].dive);
      check($sformatf("row%0d_shoot", r), int'(mif.shoot_missile), vt[r].shoot);
      check($sformatf("row%0d_pulses", r), pulse_cnt, vt[r].pulses);
      check($sformatf("row%0d_shots", r), int'(shots_fired), vt[r].shots);
    end

    // Alive drop on the frame a pulse is due suppresses it and clears the count.
    go_idle();
    PlayerX = 10'd0;
    AlienX = 10'd300;
    AlienY = 10'd100;
    mif.missile_visible = 1'b0;
    tick();
    pulse_cnt = 0;
    repeat (89) tick();
    check("pre_due_pulses", pulse_cnt, 0);
    alien_alive = 1'b0;
    tick();
    check("drop_shoot", int'(mif.shoot_missile), 0);
    check("drop_code", int'(mif.motion_code), 3);
    check("drop_shots", int'(shots_fired), 5);
    alien_alive = 1'b1;
    tick();
    ticks_to_pulse(n);
    check("pulse_after_revive", n, 90);
    check("shots_after_revive", int'(shots_fired), 6);

    // Reach a dive, fire its shot, then reset while the pulse is high.
    mif.missile_visible = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (mif.motion_code != 2'b10 && n < 400);
    check("dive_reached_code", int'(mif.motion_code), 2);
    mif.missile_visible = 1'b0;
    PlayerX = 10'd300;
    AlienX = 10'd323;
    tick();
    check("dive_shot", int'(mif.shoot_missile), 1);
    Reset_n = 1'b0;
    #1;
    check("async_rst_shoot", int'(mif.shoot_missile), 0);
    check("async_rst_code", int'(mif.motion_code), 3);
    check("async_rst_dive", int'(dive_active), 0);
    check("async_rst_shots", int'(shots_fired), 0);
    #2;
    Reset_n = 1'b1;
    tick();

    check("no_back_to_back_pulses", consec_viol, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
